// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported instruction/data memory
// between instruction fetch (IF) and load/store (MEM) of the RV32 pipeline.
// Each access is latched at grant and held until ram_ready. A one-cycle
// RESP state follows, during which the pipeline is released. Ties alternate
// between fetch and data so that neither requester starves.
// Optional build macro: ARB_PERF_CNT_EN adds saturating stall-cycle counters
// (perf_data_wait, perf_fetch_wait).
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              pc_stall,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_data_wait,
  output logic [31:0]       perf_fetch_wait,
`endif
  output logic              pipe_stall
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_served;
  logic                r_last_grant;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [DATA_W-1:0]   r_wdata_q;
  logic                r_we_q;
  logic [DATA_W-1:0]   r_if_instr;
  logic [DATA_W-1:0]   r_dm_rdata;

  logic                w_dm_req;
  logic                w_grant_data;
  logic                w_grant_fetch;
  logic                w_in_access;
  logic                w_pipe_stall;
  logic                w_pc_stall;

  assign w_dm_req    = dm_rd | dm_wr;
  assign w_in_access = (r_state == FETCH) || (r_state == DATA);

  // Next-state selection and grant decision made only from IDLE
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_data  = 1'b0;
    w_grant_fetch = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_dm_req && (r_last_grant == GRANT_FETCH || !if_req)) begin
          w_grant_data = 1'b1;
          w_state_nxt  = DATA;
        end else if (if_req) begin
          w_grant_fetch = 1'b1;
          w_state_nxt   = FETCH;
        end
      end
      FETCH, DATA: begin
        if (ram_ready) w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, access latch and result capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_served     <= 1'b0;
      r_last_grant <= GRANT_FETCH;
      r_addr_q     <= '0;
      r_wdata_q    <= '0;
      r_we_q       <= 1'b0;
      r_if_instr   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_data) begin
        r_addr_q     <= dm_addr;
        r_wdata_q    <= dm_wdata;
        r_we_q       <= dm_wr;
        r_last_grant <= GRANT_DATA;
      end else if (w_grant_fetch) begin
        r_addr_q     <= if_addr;
        r_we_q       <= 1'b0;
        r_last_grant <= GRANT_FETCH;
      end
      if (r_state == FETCH && ram_ready) begin
        r_if_instr <= ram_rdata;
        r_served   <= 1'b0;
      end
      if (r_state == DATA && ram_ready) begin
        if (!r_we_q) r_dm_rdata <= ram_rdata;
        r_served <= 1'b1;
      end
    end
  end

  // Stalls release in the completion cycle so each request is served once
  always_comb begin
    w_pipe_stall = w_dm_req & ~(r_state == RESP && r_served);
    w_pc_stall   = w_pipe_stall | (if_req & ~(r_state == RESP && !r_served));
  end

  // Outputs are held at zero while reset is asserted
  always_comb begin
    ram_en     = ~rst & w_in_access;
    ram_we     = ~rst & r_we_q & (r_state == DATA);
    ram_addr   = rst ? '0 : r_addr_q;
    ram_wdata  = rst ? '0 : r_wdata_q;
    if_instr   = rst ? '0 : r_if_instr;
    dm_rdata   = rst ? '0 : r_dm_rdata;
    if_valid   = ~rst & (r_state == RESP) & ~r_served;
    dm_done    = ~rst & (r_state == RESP) & r_served;
    pipe_stall = ~rst & w_pipe_stall;
    pc_stall   = ~rst & w_pc_stall;
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_data_wait;
  logic [31:0] r_perf_fetch_wait;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Stall-cycle counters, saturating at all ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_data_wait  <= '0;
      r_perf_fetch_wait <= '0;
    end else begin
      if (w_pipe_stall) r_perf_data_wait <= sat_inc(r_perf_data_wait);
      if (w_pc_stall && !w_pipe_stall) r_perf_fetch_wait <= sat_inc(r_perf_fetch_wait);
    end
  end

  assign perf_data_wait  = r_perf_data_wait;
  assign perf_fetch_wait = r_perf_fetch_wait;
`endif

endmodule
